antilog: RTL and testbench

Iterative fixed-point base-2 antilogarithm unit: converts an 8-bit log code (3-bit integer exponent, 5-bit fraction) back into an 8-bit unsigned integer, number = round(2^(e + c/32)). It is the inverse stage of the frontend log converter and consumes the same {e[2:0], c[4:0]} format. It is placed after log-domain processing to return values to the linear domain.

---
 rtl/antilog.sv | 116 +++++++++++
 tb/tb_antilog.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/antilog.sv
//------------------------------------------------------------------------------
// antilog : iterative base-2 antilogarithm, {e[2:0], c[4:0]} -> round(2^(e+c/32))
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module antilog #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] log_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] number_o,
    output logic                  valid_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ITER  = 2'd1,
        S_SCALE = 2'd2
    } state_t;

    state_t                  r_state;
    logic [10:0]             r_m;
    logic [2:0]              r_k;
    logic [2:0]              r_e;
    logic [4:0]              r_c;
    logic                    r_ready;
    logic                    r_valid;
    logic [DATA_WIDTH-1:0]   r_number;

    logic [10:0]             w_kc;
    logic                    w_bit;
    logic [21:0]             w_prod;
    logic [21:0]             w_mshift;
    logic [10:0]             w_mnext;
    logic [17:0]             w_sc;
    logic [17:0]             w_r;
    logic [DATA_WIDTH-1:0]   w_num;

    // Q1.10 root-of-two constant and fraction bit for the current step
    always_comb begin
        w_kc  = 11'd1046;
        w_bit = r_c[0];
        case (r_k)
            3'd4:    begin w_kc = 11'd1448; w_bit = r_c[4]; end
            3'd3:    begin w_kc = 11'd1218; w_bit = r_c[3]; end
            3'd2:    begin w_kc = 11'd1117; w_bit = r_c[2]; end
            3'd1:    begin w_kc = 11'd1069; w_bit = r_c[1]; end
            default: begin w_kc = 11'd1046; w_bit = r_c[0]; end
        endcase
    end

    assign w_prod   = {11'd0, r_m} * {11'd0, w_kc};
    assign w_mshift = (w_prod + 22'd512) >> 10;
    assign w_mnext  = (|w_mshift[21:11]) ? 11'h7FF : w_mshift[10:0];

    assign w_sc  = {7'd0, r_m} << r_e;
    assign w_r   = (w_sc + 18'd512) >> 10;
    assign w_num = (|w_r[17:DATA_WIDTH]) ? {DATA_WIDTH{1'b1}} : w_r[DATA_WIDTH-1:0];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state  <= S_IDLE;
            r_m      <= 11'd0;
            r_k      <= 3'd0;
            r_e      <= 3'd0;
            r_c      <= 5'd0;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_number <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        r_e     <= log_i[7:5];
                        r_c     <= log_i[4:0];
                        r_m     <= 11'd1024;
                        r_k     <= 3'd4;
                        r_ready <= 1'b0;
                        r_state <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (w_bit) begin
                        r_m <= w_mnext;
                    end
                    r_k <= r_k - 3'd1;
                    if (r_k == 3'd0) begin
                        r_state <= S_SCALE;
                    end
                end
                S_SCALE: begin
                    r_number <= w_num;
                    r_valid  <= 1'b1;
                    r_ready  <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o  = r_ready;
    assign valid_o  = r_valid;
    assign number_o = r_number;

endmodule

`default_nettype wire

// File: tb/tb_antilog.sv
//------------------------------------------------------------------------------
// tb_antilog : directed + exhaustive checks of antilog against a reference model
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_antilog;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic       valid_i;
    logic [7:0] log_i;
    logic       ready_o;
    logic [7:0] number_o;
    logic       valid_o;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    antilog #(.DATA_WIDTH(8)) dut (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .valid_i  (valid_i),
        .log_i    (log_i),
        .ready_o  (ready_o),
        .number_o (number_o),
        .valid_o  (valid_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: multiply in 2^(2^-j) for each set fraction bit, MSB first,
    // then scale by 2^e with round-half-up and saturate.
    function automatic int ref_antilog(input int code);
        int kt[5] = '{1046, 1069, 1117, 1218, 1448};
        int e = (code >> 5) & 7;
        int c = code & 31;
        int m = 1024;
        int r;
        for (int b = 4; b >= 0; b--) begin
            if (((c >> b) & 1) == 1) m = (m * kt[b] + 512) / 1024;
        end
        r = ((m << e) + 512) / 1024;
        if (r > 255) r = 255;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Cycle model: a conversion occupies the unit for 7 cycles after acceptance.
    int md_cnt  = 0;
    int md_pend = 0;
    int md_num  = 0;
    bit md_vld  = 1'b0;

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            md_cnt <= 0;
            md_num <= 0;
            md_vld <= 1'b0;
        end else if (md_cnt == 0) begin
            md_vld <= 1'b0;
            if (valid_i) begin
                md_pend <= ref_antilog(int'(log_i));
                md_cnt  <= 6;
            end
        end else begin
            md_cnt <= md_cnt - 1;
            if (md_cnt == 1) begin
                md_num <= md_pend;
                md_vld <= 1'b1;
            end else begin
                md_vld <= 1'b0;
            end
        end
    end

    always @(negedge clk_i) begin
        if (cmp_en && rstn_i) begin
            check("cyc_ready",  int'(ready_o),  (md_cnt == 0) ? 1 : 0);
            check("cyc_valid",  int'(valid_o),  int'(md_vld));
            check("cyc_number", int'(number_o), md_num);
        end
    end

    task automatic conv(input logic [7:0] code, output int res, output int lat);
        @(negedge clk_i);
        valid_i = 1'b1;
        log_i   = code;
        res = -1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_i);
            valid_i = 1'b0;
            if (valid_o) begin
                res = int'(number_o);
                lat = i;
                break;
            end
        end
        if (lat == 0) check("conv_timeout", 0, 1);
    endtask

    initial begin
        int  res, lat, nv;
        int  pk[$];
        int  pr[$];
        real ex, diff;

        rstn_i  = 1'b0;
        valid_i = 1'b0;
        log_i   = 8'h00;
        repeat (3) @(negedge clk_i);
        check("rst_number", int'(number_o), 0);
        check("rst_valid",  int'(valid_o),  0);
        check("rst_ready",  int'(ready_o),  1);
        rstn_i = 1'b1;
        cmp_en = 1'b1;

        check("model_00", ref_antilog(8'h00), 1);
        check("model_30", ref_antilog(8'h30), 3);
        check("model_ff", ref_antilog(8'hFF), 250);

        conv(8'h00, res, lat);
        check("code_00", res, 1);
        check("lat_00",  lat, 7);
        conv(8'h60, res, lat);
        check("code_60", res, 8);
        conv(8'hA0, res, lat);
        check("code_a0", res, 32);
        conv(8'h30, res, lat);
        check("code_30", res, 3);
        conv(8'hFF, res, lat);
        check("code_ff", res, 250);
        check("lat_ff",  lat, 7);

        // valid_i held high; only codes at accept edges may be converted
        @(negedge clk_i);
        for (int k = 0; k <= 21; k++) begin
            if (k > 0) @(negedge clk_i);
            if (valid_o) begin
                pk.push_back(k);
                pr.push_back(int'(number_o));
            end
            valid_i = (k <= 14);
            log_i   = (k == 0) ? 8'h00 : (k == 7) ? 8'h60 : (k == 14) ? 8'hFF : 8'(8'hC3 + k);
        end
        valid_i = 1'b0;
        check("b2b_count", pk.size(), 3);
        if (pk.size() == 3) begin
            check("b2b_t0", pk[0], 7);
            check("b2b_t1", pk[1], 14);
            check("b2b_t2", pk[2], 21);
            check("b2b_r0", pr[0], 1);
            check("b2b_r1", pr[1], 8);
            check("b2b_r2", pr[2], 250);
        end

        // Reset in the middle of a conversion
        @(negedge clk_i);
        valid_i = 1'b1;
        log_i   = 8'hFF;
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b0;
        #1;
        check("arst_number", int'(number_o), 0);
        check("arst_valid",  int'(valid_o),  0);
        check("arst_ready",  int'(ready_o),  1);
        @(negedge clk_i);
        rstn_i = 1'b1;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (valid_o) nv++;
        end
        check("arst_no_pulse", nv, 0);
        check("arst_hold_num", int'(number_o), 0);

        for (int code = 0; code < 256; code++) begin
            conv(8'(code), res, lat);
            check("sweep_exact", res, ref_antilog(code));
            ex   = 2.0 ** (real'((code >> 5) & 7) + real'(code & 31) / 32.0);
            diff = real'(res) - ex;
            check("sweep_tol", (diff <= 1.0 && diff >= -1.0) ? 1 : 0, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
